// File: rtl/tstate_sequencer_if.sv
// tstate_sequencer_if: bundles the sequencer's control inputs and T-state
// outputs. The master modport belongs to the controller side, which drives
// ring_len/end_cyc/hlt. The slave modport belongs to the sequencer itself.
interface tstate_sequencer_if #(
    parameter int N_STATES = 18,
    parameter int IDX_W    = 5,
    parameter int CNT_W    = 16
);
    logic [IDX_W-1:0]    ring_len;
    logic                end_cyc;
    logic                hlt;
    logic [N_STATES-1:0] state;
    logic [IDX_W-1:0]    t_idx;
    logic                first;
    logic                last;
    logic [CNT_W-1:0]    icount;
    logic                err;

    modport master (
        output ring_len, end_cyc, hlt,
        input  state, t_idx, first, last, icount, err
    );

    modport slave (
        input  ring_len, end_cyc, hlt,
        output state, t_idx, first, last, icount, err
    );
endinterface

// File: rtl/tstate_sequencer.sv
// tstate_sequencer: one-hot T-state ring for the SAP-II controller.
// The ring length is programmable at runtime. The block also supports early
// end-of-instruction, halt-hold and a count of completed instruction cycles.
// Optional feature macro: TSEQ_ONEHOT_CHECK_EN enables a checker that compares
// the one-hot state against the binary index. On a mismatch it flags err for
// one cycle and forces the ring back to T1.
module tstate_sequencer #(
    parameter int N_STATES = 18,
    parameter int IDX_W    = $clog2(N_STATES + 1),
    parameter int CNT_W    = 16
) (
    input  logic CLK,
    input  logic nCLR,
    tstate_sequencer_if.slave bus
);
    localparam logic [IDX_W-1:0]    MAX_LEN = IDX_W'(N_STATES);
    localparam logic [N_STATES-1:0] T1      = {{(N_STATES-1){1'b0}}, 1'b1};
    localparam logic [N_STATES-1:0] ONES    = {N_STATES{1'b1}};

    logic [N_STATES-1:0] state_q;
    logic [N_STATES-1:0] state_d;
    logic [N_STATES-1:0] rotated;
    logic [N_STATES-1:0] len_mask;
    logic                top_bit;
    logic [IDX_W-1:0]    idx_q;
    logic [IDX_W-1:0]    idx_d;
    logic [IDX_W-1:0]    eff_len;
    logic [IDX_W-1:0]    last_idx;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_d;
    logic                wrap;

    // Effective ring length: 0 or out-of-range lengths mean the full ring.
    always_comb begin
        eff_len = bus.ring_len;
        if (bus.ring_len == '0 || bus.ring_len > MAX_LEN) begin
            eff_len = MAX_LEN;
        end
    end

    assign last_idx = eff_len - IDX_W'(1);
    assign wrap     = bus.end_cyc || (idx_q >= last_idx);

    // Next ring position. The one-hot pattern rotates within eff_len, so a
    // valid T(last) naturally lands on T1. An early end, or an index stranded
    // above a shrunken ring, reloads T1 directly.
    always_comb begin
        len_mask = ~(ONES << eff_len);
        top_bit  = |(state_q & (T1 << last_idx));
        rotated  = ((state_q << 1) | {{(N_STATES-1){1'b0}}, top_bit}) & len_mask;
        state_d  = rotated;
        idx_d    = idx_q + IDX_W'(1);
        cnt_d    = cnt_q;
        if (wrap) begin
            idx_d = '0;
            cnt_d = cnt_q + CNT_W'(1);
            if (bus.end_cyc || idx_q != last_idx) begin
                state_d = T1;
            end
        end
    end

`ifdef TSEQ_ONEHOT_CHECK_EN
    logic onehot_bad;
    logic err_q;

    assign onehot_bad = (state_q != (T1 << idx_q)) || ($countones(state_q) != 1);

    // Error flag: a one-cycle pulse registered from the checker result.
    always_ff @(posedge CLK or negedge nCLR) begin
        if (!nCLR) begin
            err_q <= 1'b0;
        end else begin
            err_q <= onehot_bad;
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    // Sequencer registers. Priority is reset, then (optional) recovery, then
    // halt, then wrap or advance.
    always_ff @(posedge CLK or negedge nCLR) begin
        if (!nCLR) begin
            state_q <= T1;
            idx_q   <= '0;
            cnt_q   <= '0;
        end
`ifdef TSEQ_ONEHOT_CHECK_EN
        else if (onehot_bad) begin
            state_q <= T1;
            idx_q   <= '0;
        end
`endif
        else if (!bus.hlt) begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.state  = state_q;
    assign bus.t_idx  = idx_q;
    assign bus.icount = cnt_q;
    assign bus.first  = (idx_q == '0);
    assign bus.last   = (idx_q == last_idx);

endmodule
